// File: rtl/uart_tx_fifo.sv
// UART transmitter with a FIFO-buffered valid/ready input and configurable frame format.
// Optional break generation is compiled in with `define UART_TX_BREAK_EN (adds input brk).
`timescale 1ns/1ps

module uart_tx_fifo #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned BAUD_RATE   = 9600,
    parameter int unsigned CLK_FREQ    = 100_000_000,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [DATA_WIDTH-1:0]         data,
    input  logic                          valid,
`ifdef UART_TX_BREAK_EN
    input  logic                          brk,
`endif
    output logic                          ready,
    output logic                          sig,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int unsigned PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
    localparam int unsigned TW          = $clog2(PULSE_WIDTH);
    localparam int unsigned AW          = $clog2(FIFO_DEPTH);
    localparam int unsigned CW          = AW + 1;
    localparam int unsigned BW          = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
`ifdef UART_TX_BREAK_EN
        S_STOP,
        S_BRK,
        S_BRK_GAP
`else
        S_STOP
`endif
    } state_e;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;

    state_e                state_q;
    logic [TW-1:0]         timer_q;
    logic [BW-1:0]         bit_q;
    logic                  stop_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_q;
    logic                  sig_q;

    logic                  push_c, pop_c, full_c, empty_c;
    logic                  bit_end_c, last_stop_c, par_c;
    logic [DATA_WIDTH-1:0] word_c;

    assign full_c      = (count_q == CW'(FIFO_DEPTH));
    assign empty_c     = (count_q == '0);
    assign ready       = rstn && !full_c;
    assign push_c      = valid && ready;
    assign bit_end_c   = (timer_q == TW'(PULSE_WIDTH - 1));
    assign last_stop_c = (stop_q == 1'(STOP_BITS - 1));
    assign word_c      = mem_q[rd_ptr_q];
    assign par_c       = (PARITY_MODE == 2) ? ~^word_c : ^word_c;

    assign sig   = sig_q;
    assign count = count_q;
    assign busy  = (state_q != S_IDLE) || (count_q != '0);

    // Pop exactly on the edge where a new frame's start bit is launched.
    always_comb begin
        pop_c = 1'b0;
        case (state_q)
            S_IDLE:    pop_c = !empty_c;
            S_STOP:    pop_c = bit_end_c && last_stop_c && !empty_c;
`ifdef UART_TX_BREAK_EN
            S_BRK_GAP: pop_c = bit_end_c && !empty_c;
`endif
            default:   pop_c = 1'b0;
        endcase
`ifdef UART_TX_BREAK_EN
        if (brk) pop_c = 1'b0;
`endif
    end

    // Storage array needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            sig_q   <= 1'b1;
        end else begin
            timer_q <= bit_end_c ? '0 : timer_q + TW'(1);
            case (state_q)
                S_IDLE: begin
                    timer_q <= '0;
                    if (pop_c) begin
                        state_q <= S_START;
                        shift_q <= word_c;
                        par_q   <= par_c;
                        sig_q   <= 1'b0;
                    end
`ifdef UART_TX_BREAK_EN
                    else if (brk) begin
                        state_q <= S_BRK;
                        sig_q   <= 1'b0;
                    end
`endif
                end
                S_START: begin
                    if (bit_end_c) begin
                        state_q <= S_DATA;
                        bit_q   <= '0;
                        sig_q   <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                end
                S_DATA: begin
                    if (bit_end_c) begin
                        if (bit_q == BW'(DATA_WIDTH - 1)) begin
                            stop_q <= 1'b0;
                            if (PARITY_MODE != 0) begin
                                state_q <= S_PARITY;
                                sig_q   <= par_q;
                            end else begin
                                state_q <= S_STOP;
                                sig_q   <= 1'b1;
                            end
                        end else begin
                            bit_q   <= bit_q + BW'(1);
                            sig_q   <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end_c) begin
                        state_q <= S_STOP;
                        stop_q  <= 1'b0;
                        sig_q   <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end_c) begin
                        if (!last_stop_c) begin
                            stop_q <= 1'b1;
                        end else if (pop_c) begin
                            state_q <= S_START;
                            shift_q <= word_c;
                            par_q   <= par_c;
                            sig_q   <= 1'b0;
                        end
`ifdef UART_TX_BREAK_EN
                        else if (brk) begin
                            state_q <= S_BRK;
                            sig_q   <= 1'b0;
                        end
`endif
                        else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
`ifdef UART_TX_BREAK_EN
                // Line held low while brk; release starts a one-bit idle guard.
                S_BRK: begin
                    timer_q <= '0;
                    if (!brk) begin
                        state_q <= S_BRK_GAP;
                        sig_q   <= 1'b1;
                    end
                end
                S_BRK_GAP: begin
                    if (bit_end_c) begin
                        if (pop_c) begin
                            state_q <= S_START;
                            shift_q <= word_c;
                            par_q   <= par_c;
                            sig_q   <= 1'b0;
                        end else if (brk) begin
                            state_q <= S_BRK;
                            sig_q   <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    sig_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule
